perf_counter_unit: RTL and testbench

//  Producer side of the CPU performance-counter interface. Sits beside the pipeline and

---
 rtl/perf_counter_unit.sv | 131 +++++++++++++
 tb/tb_perf_counter_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : perf_counter_unit
// Description : Retire-class, cycle and stall performance counters with a
//               halt/watchdog completion flag and a registered readback port.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_unit #(
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 1024,
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [1:0]       retire_class,
    input  logic             retire_halt,
    input  logic             stall,
    input  logic [2:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] total_instructions,
    output logic [WIDTH-1:0] total_loads,
    output logic [WIDTH-1:0] total_stores,
    output logic [WIDTH-1:0] total_alus,
    output logic [WIDTH-1:0] total_controls,
    output logic [WIDTH-1:0] total_cycles,
    output logic [WIDTH-1:0] total_stall_cycles,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam int               IDLE_W    = $clog2(TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};

    state_t            state;
    state_t            state_next;
    logic              wd_fire;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WIDTH-1:0]  rd_mux;
    logic              is_alu;
    logic              is_load;
    logic              is_store;
    logic              is_control;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value,
                                                 input logic             en);
        if (en && (value != CNT_MAX)) begin
            return value + WIDTH'(1);
        end
        return value;
    endfunction

    assign is_alu     = retire_valid && (retire_class == 2'b00);
    assign is_load    = retire_valid && (retire_class == 2'b01);
    assign is_store   = retire_valid && (retire_class == 2'b10);
    assign is_control = retire_valid && (retire_class == 2'b11);

    // A retiring halt always beats the watchdog, and any retire resets it.
    always_comb begin
        state_next = state;
        wd_fire    = 1'b0;
        if (state == ST_RUN) begin
            if (retire_valid && retire_halt) begin
                state_next = ST_DONE;
            end else if (TIMEOUT_EN && !retire_valid && (idle_cnt == IDLE_LAST)) begin
                state_next = ST_DONE;
                wd_fire    = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            3'd0:    rd_mux = total_instructions;
            3'd1:    rd_mux = total_loads;
            3'd2:    rd_mux = total_stores;
            3'd3:    rd_mux = total_alus;
            3'd4:    rd_mux = total_controls;
            3'd5:    rd_mux = total_cycles;
            3'd6:    rd_mux = total_stall_cycles;
            default: rd_mux = {{(WIDTH-2){1'b0}}, timeout, done};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= ST_RUN;
            idle_cnt           <= '0;
            rd_data            <= '0;
            total_instructions <= '0;
            total_loads        <= '0;
            total_stores       <= '0;
            total_alus         <= '0;
            total_controls     <= '0;
            total_cycles       <= '0;
            total_stall_cycles <= '0;
            done               <= 1'b0;
            timeout            <= 1'b0;
        end else begin
            rd_data <= rd_mux;
            state   <= state_next;
            if (state == ST_RUN) begin
                total_cycles       <= sat_inc(total_cycles, 1'b1);
                total_stall_cycles <= sat_inc(total_stall_cycles, stall);
                total_instructions <= sat_inc(total_instructions, retire_valid);
                total_alus         <= sat_inc(total_alus, is_alu);
                total_loads        <= sat_inc(total_loads, is_load);
                total_stores       <= sat_inc(total_stores, is_store);
                total_controls     <= sat_inc(total_controls, is_control);
                if (retire_valid) begin
                    idle_cnt <= '0;
                end else if (TIMEOUT_EN) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
                done    <= (state_next == ST_DONE);
                timeout <= wd_fire;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_perf_counter_unit
// Description : Directed bench with a reference model for a 32-bit unit
//               (watchdog on) and a 4-bit unit (watchdog off) sharing stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_unit;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       retire_valid;
    logic [1:0] retire_class;
    logic       retire_halt;
    logic       stall;
    logic [2:0] rd_sel;

    // index 0..6 = instr, loads, stores, alus, controls, cycles, stalls; 7 = rd_data
    logic [31:0] a0 [8];
    logic [3:0]  a1 [8];
    logic        done0, to0, done1, to1;

    int nvec = 0;
    int nerr = 0;
    bit checking = 1'b0;

    string names [8] = '{"instr", "loads", "stores", "alus", "controls",
                         "cycles", "stalls", "rd_data"};

    always #5 clk = ~clk;

    perf_counter_unit #(.WIDTH(32), .TIMEOUT(TO), .TIMEOUT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_class(retire_class),
        .retire_halt(retire_halt), .stall(stall), .rd_sel(rd_sel), .rd_data(a0[7]),
        .total_instructions(a0[0]), .total_loads(a0[1]), .total_stores(a0[2]),
        .total_alus(a0[3]), .total_controls(a0[4]), .total_cycles(a0[5]),
        .total_stall_cycles(a0[6]), .done(done0), .timeout(to0)
    );

    perf_counter_unit #(.WIDTH(4), .TIMEOUT(TO), .TIMEOUT_EN(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_class(retire_class),
        .retire_halt(retire_halt), .stall(stall), .rd_sel(rd_sel), .rd_data(a1[7]),
        .total_instructions(a1[0]), .total_loads(a1[1]), .total_stores(a1[2]),
        .total_alus(a1[3]), .total_controls(a1[4]), .total_cycles(a1[5]),
        .total_stall_cycles(a1[6]), .done(done1), .timeout(to1)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_cnt [2][7];
    logic [31:0] m_rd  [2];
    bit          m_done[2];
    bit          m_to  [2];
    int          m_idle[2];
    logic [31:0] m_max [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
    bit          m_te  [2] = '{1'b1, 1'b0};

    function automatic int class_index(input logic [1:0] c);
        case (c)
            2'b00:   return 3;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 4;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                for (int k = 0; k < 7; k++) m_cnt[i][k] = 0;
                m_rd[i] = 0; m_done[i] = 0; m_to[i] = 0; m_idle[i] = 0;
            end else begin
                m_rd[i] = (rd_sel == 3'd7) ? {30'd0, m_to[i], m_done[i]} : m_cnt[i][rd_sel];
                if (!m_done[i]) begin
                    if (m_cnt[i][5] != m_max[i]) m_cnt[i][5] += 1;
                    if (stall && m_cnt[i][6] != m_max[i]) m_cnt[i][6] += 1;
                    if (retire_valid) begin
                        if (m_cnt[i][0] != m_max[i]) m_cnt[i][0] += 1;
                        if (m_cnt[i][class_index(retire_class)] != m_max[i])
                            m_cnt[i][class_index(retire_class)] += 1;
                    end
                    if (retire_valid && retire_halt) begin
                        m_done[i] = 1;
                    end else if (m_te[i] && !retire_valid && m_idle[i] == TO - 1) begin
                        m_done[i] = 1; m_to[i] = 1;
                    end
                    m_idle[i] = retire_valid ? 0 : m_idle[i] + 1;
                end
            end
        end
        if (!rst) checking = 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 8; k++) begin
                check({"main ", names[k]}, a0[k], (k < 7) ? m_cnt[0][k] : m_rd[0]);
                check({"sat ", names[k]}, {28'd0, a1[k]}, (k < 7) ? m_cnt[1][k] : m_rd[1]);
            end
            check("main done", {31'd0, done0}, {31'd0, m_done[0]});
            check("main timeout", {31'd0, to0}, {31'd0, m_to[0]});
            check("sat done", {31'd0, done1}, {31'd0, m_done[1]});
            check("sat timeout", {31'd0, to1}, {31'd0, m_to[1]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b0; retire_valid = 1'b0; retire_halt = 1'b0; stall = 1'b0;
        step(1);
        rst = 1'b1;
    endtask

    logic [1:0] seq_class [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11};

    initial begin
        rst = 1'b0; retire_valid = 1'b0; retire_class = 2'b00; retire_halt = 1'b0;
        stall = 1'b0; rd_sel = 3'd0;

        // 1: long reset, then idle RUN
        step(5);
        check("t1 reset cycles", a0[5], 32'd0);
        check("t1 reset instr", a0[0], 32'd0);
        check("t1 reset done", {31'd0, done0}, 32'd0);
        rst = 1'b1;
        step(3);
        check("t1 cycles", a0[5], 32'd3);
        check("t1 instr", a0[0], 32'd0);

        // 2: five retires ending in halt
        do_reset();
        for (int i = 0; i < 5; i++) begin
            retire_valid = 1'b1; retire_class = seq_class[i]; retire_halt = (i == 4);
            if (i == 4) check("t2 done before halt", {31'd0, done0}, 32'd0);
            step(1);
        end
        retire_valid = 1'b0; retire_halt = 1'b0;
        check("t2 instr", a0[0], 32'd5);
        check("t2 alus", a0[3], 32'd2);
        check("t2 loads", a0[1], 32'd1);
        check("t2 stores", a0[2], 32'd1);
        check("t2 controls", a0[4], 32'd1);
        check("t2 cycles", a0[5], 32'd5);
        check("t2 done", {31'd0, done0}, 32'd1);
        step(2);
        check("t2 frozen cycles", a0[5], 32'd5);

        // 3: stall with a load during the second stall cycle
        do_reset();
        stall = 1'b1; step(1);
        retire_valid = 1'b1; retire_class = 2'b01; step(1);
        retire_valid = 1'b0; step(1);
        stall = 1'b0;
        check("t3 stalls", a0[6], 32'd3);
        check("t3 loads", a0[1], 32'd1);
        check("t3 instr", a0[0], 32'd1);

        // 4: watchdog, freeze, status readback
        do_reset();
        step(7);
        check("t4 done at 7", {31'd0, done0}, 32'd0);
        step(1);
        check("t4 done", {31'd0, done0}, 32'd1);
        check("t4 timeout", {31'd0, to0}, 32'd1);
        check("t4 cycles", a0[5], 32'd8);
        retire_valid = 1'b1; retire_class = 2'b01; stall = 1'b1;
        step(20);
        retire_valid = 1'b0; stall = 1'b0;
        check("t4 frozen instr", a0[0], 32'd0);
        check("t4 frozen cycles", a0[5], 32'd8);
        check("t4 frozen stalls", a0[6], 32'd0);
        rd_sel = 3'd7; step(1);
        check("t4 status", a0[7], 32'd3);
        rd_sel = 3'd0;

        // 4b: a retire on the last idle cycle restarts the watchdog
        do_reset();
        step(7);
        retire_valid = 1'b1; retire_class = 2'b00; step(1);
        retire_valid = 1'b0;
        step(7);
        check("t4b no timeout", {31'd0, done0}, 32'd0);
        step(1);
        check("t4b timeout", {31'd0, to0}, 32'd1);
        check("t4b cycles", a0[5], 32'd16);

        // 5: saturation on the narrow instance
        do_reset();
        step(14);
        check("t5 sat cycles E", {28'd0, a1[5]}, 32'hE);
        step(3);
        check("t5 sat cycles F", {28'd0, a1[5]}, 32'hF);

        // 6: reset mid-run, resume, readback sweep
        do_reset();
        for (int i = 0; i < 10; i++) begin
            retire_valid = 1'b1; retire_class = 2'(i % 4);
            step(1);
        end
        retire_valid = 1'b0;
        check("t6 instr", a0[0], 32'd10);
        rst = 1'b0; step(1);
        check("t6 reset instr", a0[0], 32'd0);
        check("t6 reset cycles", a0[5], 32'd0);
        check("t6 reset done", {31'd0, done0}, 32'd0);
        rst = 1'b1; retire_valid = 1'b1; retire_class = 2'b00;
        step(2);
        check("t6 resume cycles", a0[5], 32'd2);
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            step(1);
        end
        rd_sel = 3'd5; step(1);
        check("t6 rd cycles", a0[7], 32'd10);
        rd_sel = 3'd0; step(1);
        check("t6 rd instr", a0[7], 32'd11);
        retire_valid = 1'b0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
